id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 71 +++++++
 rtl/id_register_file.sv | 40 ++++
 rtl/id_stage.sv | 132 +++++++++++++
 tb/tb_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: class encodings, ARM data-processing
// opcodes, execute command codes and condition codes, plus the condition evaluator.
package id_stage_pkg;

  // Instruction class fields
  localparam logic [1:0] CLASS_DP     = 2'b00;   // instr[27:26]
  localparam logic [1:0] CLASS_MEM    = 2'b01;   // instr[27:26]
  localparam logic [2:0] CLASS_BRANCH = 3'b101;  // instr[27:25]

  // ARM data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Execute command codes
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0110;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SBC = 4'b0011;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_CMP = 4'b0101;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_MEM = 4'b0100;
  localparam logic [3:0] CMD_NOP = 4'b0000;

  // Condition codes, instr[31:28]
  typedef enum logic [3:0] {
    CondEq = 4'b0000, CondNe = 4'b0001, CondCs = 4'b0010, CondCc = 4'b0011,
    CondMi = 4'b0100, CondPl = 4'b0101, CondVs = 4'b0110, CondVc = 4'b0111,
    CondHi = 4'b1000, CondLs = 4'b1001, CondGe = 4'b1010, CondLt = 4'b1011,
    CondGt = 4'b1100, CondLe = 4'b1101, CondAl = 4'b1110, CondNv = 4'b1111
  } cond_e;

  // status = {N, Z, C, V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v, pass;
    {n, z, c, v} = status;
    unique case (cond_e'(cond))
      CondEq: pass = z;
      CondNe: pass = ~z;
      CondCs: pass = c;
      CondCc: pass = ~c;
      CondMi: pass = n;
      CondPl: pass = ~n;
      CondVs: pass = v;
      CondVc: pass = ~v;
      CondHi: pass = c & ~z;
      CondLs: pass = ~c | z;
      CondGe: pass = (n == v);
      CondLt: pass = (n != v);
      CondGt: pass = ~z & (n == v);
      CondLe: pass = z | (n != v);
      CondAl: pass = 1'b1;
      default: pass = 1'b0;  // CondNv
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_register_file.sv
// 15-entry register file (R0-R14) with two read ports and write-through bypass.
// Index 15 is not storage: writes to it are dropped and reads return zero.
module id_register_file #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            rd_addr_a,
  input  logic [3:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  logic [DATA_WIDTH-1:0] regs [0:14];

  // Storage update; async clear of every register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we && wr_addr != 4'd15) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: bypass a same-cycle write so decode sees the value being written back
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != 4'd15) begin
      rd_data_a = (we && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    end
    if (rd_addr_b != 4'd15) begin
      rd_data_b = (we && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end
  end

endmodule

// File: rtl/id_stage.sv
// ARM-subset instruction decode stage: decodes class/command, evaluates the
// condition field, reads operands and registers everything into the ID/EX latch.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_Pc,
  input  logic [31:0]           i_Instruction,
  input  logic [3:0]            i_Status,
  input  logic                  i_Sig_Write_Back,
  input  logic [DATA_WIDTH-1:0] i_Write_Back_Value,
  input  logic [3:0]            i_Write_Back_Destination,
  input  logic                  i_Sig_Hazard,
  output logic [DATA_WIDTH-1:0] o_Pc,
  output logic                  o_Sig_Memory_Read_Enable,
  output logic                  o_Sig_Memory_Write_Enable,
  output logic                  o_Write_Back_Enable,
  output logic                  o_Sig_Branch_Taken,
  output logic                  o_Immediate,
  output logic [3:0]            o_Sigs_Control,
  output logic [DATA_WIDTH-1:0] o_Rm_Value,
  output logic [DATA_WIDTH-1:0] o_Rn_Value,
  output logic [23:0]           o_Signed_Immediate_24,
  output logic [3:0]            o_Destination,
  output logic [11:0]           o_Shift_Operand,
  output logic                  o_Two_Src,
  output logic [3:0]            o_Rn,
  output logic [3:0]            o_Src_2
);

  logic                  is_dp, is_mem, is_branch, is_load, is_store;
  logic [3:0]            opcode;
  logic [3:0]            cmd;
  logic                  wb;
  logic                  active;
  logic                  two_src;
  logic [3:0]            src_2;
  logic [DATA_WIDTH-1:0] rn_value, rm_value;

  assign opcode    = i_Instruction[24:21];
  assign is_dp     = (i_Instruction[27:26] == CLASS_DP);
  assign is_mem    = (i_Instruction[27:26] == CLASS_MEM);
  assign is_branch = (i_Instruction[27:25] == CLASS_BRANCH);
  assign is_load   = is_mem & i_Instruction[20];
  assign is_store  = is_mem & ~i_Instruction[20];

  // A failed condition or a stall turns the instruction into a bubble
  assign active  = cond_pass(i_Instruction[31:28], i_Status) & ~i_Sig_Hazard;
  assign two_src = (is_dp & ~i_Instruction[25]) | is_store;
  // STR carries its store data register in the Rd field
  assign src_2   = is_store ? i_Instruction[15:12] : i_Instruction[3:0];

  id_register_file #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_register_file (
    .clk       (clk),
    .reset     (reset),
    .we        (i_Sig_Write_Back),
    .wr_addr   (i_Write_Back_Destination),
    .wr_data   (i_Write_Back_Value),
    .rd_addr_a (i_Instruction[19:16]),
    .rd_addr_b (src_2),
    .rd_data_a (rn_value),
    .rd_data_b (rm_value)
  );

  // Command code and write-back decode; unsupported opcodes decode as a no-op
  always_comb begin
    cmd = CMD_NOP;
    wb  = 1'b0;
    if (is_dp) begin
      case (opcode)
        OP_MOV:  begin cmd = CMD_MOV; wb = 1'b1; end
        OP_MVN:  begin cmd = CMD_MVN; wb = 1'b1; end
        OP_ADD:  begin cmd = CMD_ADD; wb = 1'b1; end
        OP_ADC:  begin cmd = CMD_ADC; wb = 1'b1; end
        OP_SUB:  begin cmd = CMD_SUB; wb = 1'b1; end
        OP_SBC:  begin cmd = CMD_SBC; wb = 1'b1; end
        OP_AND:  begin cmd = CMD_AND; wb = 1'b1; end
        OP_ORR:  begin cmd = CMD_ORR; wb = 1'b1; end
        OP_EOR:  begin cmd = CMD_EOR; wb = 1'b1; end
        OP_CMP:  cmd = CMD_CMP;
        OP_TST:  cmd = CMD_TST;
        default: cmd = CMD_NOP;
      endcase
    end else if (is_mem) begin
      cmd = CMD_MEM;
      wb  = is_load;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_Pc                      <= '0;
      o_Sig_Memory_Read_Enable  <= 1'b0;
      o_Sig_Memory_Write_Enable <= 1'b0;
      o_Write_Back_Enable       <= 1'b0;
      o_Sig_Branch_Taken        <= 1'b0;
      o_Immediate               <= 1'b0;
      o_Sigs_Control            <= '0;
      o_Rm_Value                <= '0;
      o_Rn_Value                <= '0;
      o_Signed_Immediate_24     <= '0;
      o_Destination             <= '0;
      o_Shift_Operand           <= '0;
      o_Two_Src                 <= 1'b0;
      o_Rn                      <= '0;
      o_Src_2                   <= '0;
    end else begin
      o_Pc                      <= i_Pc;
      o_Sig_Memory_Read_Enable  <= active & is_load;
      o_Sig_Memory_Write_Enable <= active & is_store;
      o_Write_Back_Enable       <= active & wb;
      o_Sig_Branch_Taken        <= active & is_branch;
      o_Immediate               <= i_Instruction[25];
      o_Sigs_Control            <= active ? cmd : CMD_NOP;
      o_Rm_Value                <= rm_value;
      o_Rn_Value                <= rn_value;
      o_Signed_Immediate_24     <= i_Instruction[23:0];
      o_Destination             <= i_Instruction[15:12];
      o_Shift_Operand           <= i_Instruction[11:0];
      o_Two_Src                 <= two_src;
      o_Rn                      <= i_Instruction[19:16];
      o_Src_2                   <= src_2;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a per-cycle reference model plus directed literal checks.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_Pc, i_Instruction, i_Write_Back_Value;
  logic [3:0]  i_Status, i_Write_Back_Destination;
  logic        i_Sig_Write_Back, i_Sig_Hazard;
  logic [31:0] o_Pc, o_Rm_Value, o_Rn_Value;
  logic        o_Sig_Memory_Read_Enable, o_Sig_Memory_Write_Enable, o_Write_Back_Enable;
  logic        o_Sig_Branch_Taken, o_Immediate, o_Two_Src;
  logic [3:0]  o_Sigs_Control, o_Destination, o_Rn, o_Src_2;
  logic [23:0] o_Signed_Immediate_24;
  logic [11:0] o_Shift_Operand;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.DATA_WIDTH(32)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_Pc                      (i_Pc),
    .i_Instruction             (i_Instruction),
    .i_Status                  (i_Status),
    .i_Sig_Write_Back          (i_Sig_Write_Back),
    .i_Write_Back_Value        (i_Write_Back_Value),
    .i_Write_Back_Destination  (i_Write_Back_Destination),
    .i_Sig_Hazard              (i_Sig_Hazard),
    .o_Pc                      (o_Pc),
    .o_Sig_Memory_Read_Enable  (o_Sig_Memory_Read_Enable),
    .o_Sig_Memory_Write_Enable (o_Sig_Memory_Write_Enable),
    .o_Write_Back_Enable       (o_Write_Back_Enable),
    .o_Sig_Branch_Taken        (o_Sig_Branch_Taken),
    .o_Immediate               (o_Immediate),
    .o_Sigs_Control            (o_Sigs_Control),
    .o_Rm_Value                (o_Rm_Value),
    .o_Rn_Value                (o_Rn_Value),
    .o_Signed_Immediate_24     (o_Signed_Immediate_24),
    .o_Destination             (o_Destination),
    .o_Shift_Operand           (o_Shift_Operand),
    .o_Two_Src                 (o_Two_Src),
    .o_Rn                      (o_Rn),
    .o_Src_2                   (o_Src_2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mregs [15];

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    bit [15:0] ok;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    ok = '0;
    ok[0] = z;          ok[1] = !z;
    ok[2] = c;          ok[3] = !c;
    ok[4] = n;          ok[5] = !n;
    ok[6] = v;          ok[7] = !v;
    ok[8] = c && !z;    ok[9] = !c || z;
    ok[10] = (n == v);  ok[11] = (n != v);
    ok[12] = !z && (n == v);
    ok[13] = z || (n != v);
    ok[14] = 1'b1;      ok[15] = 1'b0;
    return ok[cc];
  endfunction

  // Returns {writes_rd, supported, command}
  function automatic logic [5:0] dp_info(input logic [3:0] op);
    case (op)
      4'd0:  return {2'b11, 4'b0000};  // AND
      4'd1:  return {2'b11, 4'b0001};  // EOR
      4'd2:  return {2'b11, 4'b0010};  // SUB
      4'd4:  return {2'b11, 4'b0100};  // ADD
      4'd5:  return {2'b11, 4'b0110};  // ADC
      4'd6:  return {2'b11, 4'b0011};  // SBC
      4'd8:  return {2'b01, 4'b1000};  // TST
      4'd10: return {2'b01, 4'b0101};  // CMP
      4'd12: return {2'b11, 4'b1100};  // ORR
      4'd13: return {2'b11, 4'b1101};  // MOV
      4'd15: return {2'b11, 4'b1111};  // MVN
      default: return 6'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] idx);
    if (idx == 4'd15) return 32'h0;
    if (i_Sig_Write_Back && i_Write_Back_Destination == idx) return i_Write_Back_Value;
    return mregs[idx];
  endfunction

  // Compute what the latch must hold after this edge, then compare shortly after it
  always @(posedge clk) begin
    logic [31:0] e_pc, e_rm, e_rn;
    logic        e_rd, e_wr, e_wb, e_br, e_imm, e_two;
    logic [3:0]  e_cmd, e_dst, e_rnidx, e_src2;
    logic [23:0] e_i24;
    logic [11:0] e_sh;
    logic [5:0]  info;
    bit          dp, ldr, str, br, go;
    {e_pc, e_rm, e_rn} = '0;
    {e_rd, e_wr, e_wb, e_br, e_imm, e_two} = '0;
    {e_cmd, e_dst, e_rnidx, e_src2, e_i24, e_sh} = '0;
    if (!reset) begin
      for (int i = 0; i < 15; i++) mregs[i] = '0;
    end else begin
      dp  = (i_Instruction[27:26] == 2'b00);
      ldr = (i_Instruction[27:26] == 2'b01) && i_Instruction[20];
      str = (i_Instruction[27:26] == 2'b01) && !i_Instruction[20];
      br  = (i_Instruction[27:25] == 3'b101);
      go  = cond_ok(i_Instruction[31:28], i_Status) && !i_Sig_Hazard;
      info = dp ? dp_info(i_Instruction[24:21]) : 6'b0;
      e_pc    = i_Pc;
      e_imm   = i_Instruction[25];
      e_i24   = i_Instruction[23:0];
      e_dst   = i_Instruction[15:12];
      e_sh    = i_Instruction[11:0];
      e_rnidx = i_Instruction[19:16];
      e_two   = (dp && !i_Instruction[25]) || str;
      e_src2  = str ? i_Instruction[15:12] : i_Instruction[3:0];
      e_rn    = mread(e_rnidx);
      e_rm    = mread(e_src2);
      if (go) begin
        e_rd  = ldr;
        e_wr  = str;
        e_br  = br;
        e_wb  = ldr || (dp && info[5]);
        e_cmd = (ldr || str) ? 4'b0100 : info[3:0];
      end
      if (i_Sig_Write_Back && i_Write_Back_Destination != 4'd15)
        mregs[i_Write_Back_Destination] = i_Write_Back_Value;
    end
    #2;
    chk("model_pc", o_Pc, e_pc);
    chk("model_mem_read", o_Sig_Memory_Read_Enable, e_rd);
    chk("model_mem_write", o_Sig_Memory_Write_Enable, e_wr);
    chk("model_wb_en", o_Write_Back_Enable, e_wb);
    chk("model_branch", o_Sig_Branch_Taken, e_br);
    chk("model_imm", o_Immediate, e_imm);
    chk("model_control", o_Sigs_Control, e_cmd);
    chk("model_rm_value", o_Rm_Value, e_rm);
    chk("model_rn_value", o_Rn_Value, e_rn);
    chk("model_imm24", o_Signed_Immediate_24, e_i24);
    chk("model_dest", o_Destination, e_dst);
    chk("model_shift_op", o_Shift_Operand, e_sh);
    chk("model_two_src", o_Two_Src, e_two);
    chk("model_rn", o_Rn, e_rnidx);
    chk("model_src2", o_Src_2, e_src2);
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [3:0] status, input logic hazard,
                       input logic wbe, input logic [3:0] wbd, input logic [31:0] wbv);
    @(negedge clk);
    i_Pc = pc; i_Instruction = instr; i_Status = status; i_Sig_Hazard = hazard;
    i_Sig_Write_Back = wbe; i_Write_Back_Destination = wbd; i_Write_Back_Value = wbv;
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b0;
    i_Pc = 32'h40; i_Instruction = 32'hE0821003; i_Status = 4'h0; i_Sig_Hazard = 1'b0;
    i_Sig_Write_Back = 1'b1; i_Write_Back_Destination = 4'd1; i_Write_Back_Value = 32'h77;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_pc", o_Pc, 32'h0);
    chk("reset_control", o_Sigs_Control, 4'h0);
    chk("reset_wb", o_Write_Back_Enable, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Preload R3 and R2; the instruction is EQ with Z=0 so it bubbles
    apply(32'h0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd3, 32'h00000005);
    chk("bubble_cond_eq_fail", o_Sigs_Control, 4'h0);
    apply(32'h4, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd2, 32'h11111111);

    // ADD R1,R2,R3
    apply(32'h8, 32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("add_control", o_Sigs_Control, 4'b0100);
    chk("add_dest", o_Destination, 4'd1);
    chk("add_two_src", o_Two_Src, 1'b1);
    chk("add_wb", o_Write_Back_Enable, 1'b1);
    chk("add_rn_value", o_Rn_Value, 32'h11111111);
    chk("add_rm_value", o_Rm_Value, 32'h00000005);

    // Write-back bypass of R2 in the same cycle
    apply(32'hC, 32'hE0821003, 4'h0, 1'b0, 1'b1, 4'd2, 32'hABCDEF00);
    chk("bypass_rn_value", o_Rn_Value, 32'hABCDEF00);

    // R15: write dropped, read returns zero even with bypass pending
    apply(32'h10, 32'hE08F1003, 4'h0, 1'b0, 1'b1, 4'd15, 32'h0000DEAD);
    chk("r15_reads_zero", o_Rn_Value, 32'h0);

    apply(32'h14, 32'hE5924000, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("ldr_mem_read", o_Sig_Memory_Read_Enable, 1'b1);
    chk("ldr_dest", o_Destination, 4'd4);
    chk("ldr_wb", o_Write_Back_Enable, 1'b1);
    chk("ldr_rn_value", o_Rn_Value, 32'hABCDEF00);

    apply(32'h18, 32'hE5835000, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("str_mem_write", o_Sig_Memory_Write_Enable, 1'b1);
    chk("str_two_src", o_Two_Src, 1'b1);
    chk("str_src2", o_Src_2, 4'd5);
    chk("str_wb", o_Write_Back_Enable, 1'b0);

    apply(32'h1C, 32'hE3A06005, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("mov_control", o_Sigs_Control, 4'b1101);
    chk("mov_imm", o_Immediate, 1'b1);
    chk("mov_shift_op", o_Shift_Operand, 12'h005);
    chk("mov_two_src", o_Two_Src, 1'b0);

    apply(32'h20, 32'hEA000003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("b_imm24", o_Signed_Immediate_24, 24'h000003);
    chk("b_taken", o_Sig_Branch_Taken, 1'b1);
    chk("b_control", o_Sigs_Control, 4'h0);

    apply(32'h24, 32'hE1570008, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("cmp_control", o_Sigs_Control, 4'b0101);
    chk("cmp_wb", o_Write_Back_Enable, 1'b0);

    apply(32'h28, 32'h00821003, 4'b0100, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("addeq_z1_control", o_Sigs_Control, 4'b0100);
    apply(32'h2C, 32'h00821003, 4'b0000, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("addeq_z0_control", o_Sigs_Control, 4'h0);
    chk("addeq_z0_wb", o_Write_Back_Enable, 1'b0);

    // GT passes with N=V=1, LE fails with the same flags, NV never executes
    apply(32'h30, 32'hC0821003, 4'b1001, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("addgt_control", o_Sigs_Control, 4'b0100);
    apply(32'h34, 32'hD0821003, 4'b1001, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("addle_control", o_Sigs_Control, 4'h0);
    apply(32'h38, 32'hF0821003, 4'b0100, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("addnv_wb", o_Write_Back_Enable, 1'b0);

    // Stall
    apply(32'd1024, 32'hE0821003, 4'h0, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("hazard_pc", o_Pc, 32'd1024);
    chk("hazard_control", o_Sigs_Control, 4'h0);
    chk("hazard_wb", o_Write_Back_Enable, 1'b0);
    chk("hazard_dest", o_Destination, 4'd1);

    // Mid-cycle async reset clears outputs and register contents
    apply(32'h3C, 32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_control", o_Sigs_Control, 4'h0);
    chk("async_reset_pc", o_Pc, 32'h0);
    chk("async_reset_rn_value", o_Rn_Value, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(32'h40, 32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("post_reset_rn_cleared", o_Rn_Value, 32'h0);
    chk("post_reset_control", o_Sigs_Control, 4'b0100);

    repeat (2) @(posedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
